// File: rtl/snn_cfg_pkg.sv
// Shared widths, frame constants and FSM encoding for the SNN
// configuration loader and the core it feeds.
package snn_cfg_pkg;

  localparam int NBITS   = 2;
  localparam int W_BYTES = 52;
  localparam int D_BYTES = 104;
  localparam logic [7:0] HDR_BYTE = 8'hA5;

  localparam int WEIGHT_W = 8 * W_BYTES;
  localparam int DELAY_W  = 8 * D_BYTES;

  localparam logic [6:0] W_LAST = 7'(W_BYTES - 1);
  localparam logic [6:0] D_LAST = 7'(D_BYTES - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD_W = 3'd1;
  localparam logic [2:0] ST_LOAD_D = 3'd2;
  localparam logic [2:0] ST_LOAD_P = 3'd3;
  localparam logic [2:0] ST_CHECK  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;
  localparam logic [2:0] ST_ERR    = 3'd6;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    LOAD_W = ST_LOAD_W,
    LOAD_D = ST_LOAD_D,
    LOAD_P = ST_LOAD_P,
    CHECK  = ST_CHECK,
    DONE   = ST_DONE,
    ERR    = ST_ERR
  } state_t;

  localparam int THR_LSB = 0;
  localparam int DEC_LSB = 2;
  localparam int REF_LSB = 4;

  function automatic logic is_rest(state_t s);
    return (s == IDLE) || (s == DONE) || (s == ERR);
  endfunction

endpackage

// File: rtl/snn_param_loader_if.sv
// Byte-serial configuration stream: one byte per cycle while
// data_valid is high.
interface snn_param_loader_if;
  logic [7:0] data_in;
  logic       data_valid;

  modport master (output data_in, output data_valid);
  modport slave  (input  data_in, input  data_valid);
endinterface

// File: rtl/snn_cfg_frame_ctrl.sv
// Frame sequencer: tracks position in the stream, running XOR
// checksum, and emits byte-write strobes for the bus registers.
module snn_cfg_frame_ctrl
  import snn_cfg_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       we_w,
  output logic       we_d,
  output logic       we_p,
  output logic [6:0] idx,
  output logic       config_valid,
  output logic       load_busy,
  output logic       load_error
);

  state_t     state;
  logic [6:0] cnt;
  logic [7:0] csum;

  assign we_w = valid && (state == LOAD_W);
  assign we_d = valid && (state == LOAD_D);
  assign we_p = valid && (state == LOAD_P);
  assign idx  = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      csum         <= '0;
      config_valid <= 1'b0;
      load_busy    <= 1'b0;
      load_error   <= 1'b0;
    end else if (valid) begin
      unique case (state)
        IDLE, DONE, ERR: begin
          if (data == HDR_BYTE) begin
            state        <= LOAD_W;
            cnt          <= '0;
            csum         <= '0;
            config_valid <= 1'b0;
            load_error   <= 1'b0;
            load_busy    <= 1'b1;
          end
        end
        LOAD_W: begin
          csum <= csum ^ data;
          if (cnt == W_LAST) begin
            cnt   <= '0;
            state <= LOAD_D;
          end else begin
            cnt <= cnt + 7'd1;
          end
        end
        LOAD_D: begin
          csum <= csum ^ data;
          if (cnt == D_LAST) begin
            cnt   <= '0;
            state <= LOAD_P;
          end else begin
            cnt <= cnt + 7'd1;
          end
        end
        LOAD_P: begin
          csum  <= csum ^ data;
          state <= CHECK;
        end
        CHECK: begin
          load_busy <= 1'b0;
          if (data == csum) begin
            config_valid <= 1'b1;
            state        <= DONE;
          end else begin
            load_error <= 1'b1;
            state      <= ERR;
          end
        end
        default: begin
          state     <= IDLE;
          load_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/snn_param_loader.sv
// Byte-serial parameter loader: assembles a framed stream into the
// weight, delay and neuron-parameter buses of the SNN core.
module snn_param_loader
  import snn_cfg_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  snn_param_loader_if.slave   cfg,
  output logic [WEIGHT_W-1:0] weights,
  output logic [DELAY_W-1:0]  delays,
  output logic [NBITS-1:0]    threshold,
  output logic [NBITS-1:0]    decay,
  output logic [NBITS-1:0]    refractory_period,
  output logic                config_valid,
  output logic                load_busy,
  output logic                load_error
);

  logic       we_w;
  logic       we_d;
  logic       we_p;
  logic [6:0] idx;

  logic [W_BYTES-1:0][7:0] w_q;
  logic [D_BYTES-1:0][7:0] d_q;

  snn_cfg_frame_ctrl u_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .data         (cfg.data_in),
    .valid        (cfg.data_valid),
    .we_w         (we_w),
    .we_d         (we_d),
    .we_p         (we_p),
    .idx          (idx),
    .config_valid (config_valid),
    .load_busy    (load_busy),
    .load_error   (load_error)
  );

  // Buses are written in place; config_valid marks them usable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q               <= '0;
      d_q               <= '0;
      threshold         <= '0;
      decay             <= '0;
      refractory_period <= '0;
    end else begin
      if (we_w) w_q[idx[5:0]] <= cfg.data_in;
      if (we_d) d_q[idx]      <= cfg.data_in;
      if (we_p) begin
        threshold         <= cfg.data_in[THR_LSB +: NBITS];
        decay             <= cfg.data_in[DEC_LSB +: NBITS];
        refractory_period <= cfg.data_in[REF_LSB +: NBITS];
      end
    end
  end

  assign weights = w_q;
  assign delays  = d_q;

endmodule

// File: tb/tb_snn_param_loader.sv
// Directed bench for snn_param_loader with a frame-level reference
// model checked every cycle.
module tb_snn_param_loader;

  logic clk;
  logic rst_n;

  logic [415:0] weights;
  logic [831:0] delays;
  logic [1:0]   threshold;
  logic [1:0]   decay;
  logic [1:0]   refractory_period;
  logic         config_valid;
  logic         load_busy;
  logic         load_error;

  snn_param_loader_if bus ();

  snn_param_loader dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .cfg               (bus.slave),
    .weights           (weights),
    .delays            (delays),
    .threshold         (threshold),
    .decay             (decay),
    .refractory_period (refractory_period),
    .config_valid      (config_valid),
    .load_busy         (load_busy),
    .load_error        (load_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit cmp_en = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [831:0] act,
                     input logic [831:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Reference model: position within the frame, -1 while waiting for a header
  int         pos;
  logic [7:0] mw [52];
  logic [7:0] md [104];
  logic [1:0] m_thr, m_dec, m_ref;
  logic       m_cv, m_err;
  logic [7:0] m_x;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos = -1;
      foreach (mw[k]) mw[k] = 8'h00;
      foreach (md[k]) md[k] = 8'h00;
      m_thr = 0; m_dec = 0; m_ref = 0;
      m_cv = 0; m_err = 0; m_x = 0;
    end else if (bus.data_valid) begin
      logic [7:0] b;
      b = bus.data_in;
      if (pos < 0) begin
        if (b == 8'hA5) begin
          pos = 0; m_x = 0; m_cv = 0; m_err = 0;
        end
      end else if (pos < 52) begin
        mw[pos] = b; m_x ^= b; pos++;
      end else if (pos < 156) begin
        md[pos-52] = b; m_x ^= b; pos++;
      end else if (pos == 156) begin
        m_thr = b[1:0]; m_dec = b[3:2]; m_ref = b[5:4];
        m_x ^= b; pos++;
      end else begin
        if (b == m_x) m_cv = 1; else m_err = 1;
        pos = -1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [415:0] ew;
      logic [831:0] ed;
      foreach (mw[k]) ew[8*k +: 8] = mw[k];
      foreach (md[k]) ed[8*k +: 8] = md[k];
      chk("m_cv",   config_valid, m_cv);
      chk("m_busy", load_busy, pos >= 0);
      chk("m_err",  load_error, m_err);
      chk("m_thr",  threshold, m_thr);
      chk("m_dec",  decay, m_dec);
      chk("m_ref",  refractory_period, m_ref);
      chk("m_w",    weights, ew);
      chk("m_d",    delays, ed);
    end
  end

  task automatic put(input logic [7:0] b);
    @(negedge clk);
    bus.data_in    = b;
    bus.data_valid = 1'b1;
  endtask

  task automatic idle(input int n, input logic [7:0] b);
    repeat (n) begin
      @(negedge clk);
      bus.data_in    = b;
      bus.data_valid = 1'b0;
    end
  endtask

  logic [7:0] fr[$];

  function automatic void build(input logic [7:0] mask);
    logic [7:0] x;
    x = 0;
    fr = {};
    fr.push_back(8'hA5);
    for (int k = 0; k < 52; k++) begin
      fr.push_back(8'(k)); x ^= 8'(k);
    end
    for (int k = 0; k < 104; k++) begin
      fr.push_back(8'(255 - k)); x ^= 8'(255 - k);
    end
    fr.push_back(8'h39); x ^= 8'h39;
    fr.push_back(x ^ mask);
  endfunction

  task automatic send(input logic [7:0] mask, input bit gap,
                      input int exp_cyc);
    int c0;
    build(mask);
    @(negedge clk);
    c0 = cyc;
    bus.data_in    = fr[0];
    bus.data_valid = 1'b1;
    for (int i = 1; i < fr.size(); i++) begin
      if (gap) idle(1, 8'hA5);
      put(fr[i]);
      if (i == fr.size() - 1) begin
        chk("pre_cv",   config_valid, 1'b0);
        chk("pre_busy", load_busy, 1'b1);
      end
    end
    @(posedge clk);
    #1;
    bus.data_valid = 1'b0;
    chk("latency", cyc - c0, exp_cyc);
  endtask

  task automatic pin_good();
    chk("cv",   config_valid, 1'b1);
    chk("busy", load_busy, 1'b0);
    chk("err",  load_error, 1'b0);
    chk("w_lo", weights[7:0], 8'h00);
    chk("w_hi", weights[415:408], 8'h33);
    chk("d_lo", delays[7:0], 8'hFF);
    chk("d_hi", delays[831:824], 8'h98);
    chk("thr",  threshold, 2'b01);
    chk("dec",  decay, 2'b10);
    chk("ref",  refractory_period, 2'b11);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.data_in = 8'h00;
    bus.data_valid = 1'b0;
    #12;
    chk("rst_w",  weights, 0);
    chk("rst_cv", config_valid, 0);
    chk("rst_busy", load_busy, 0);
    #11 rst_n = 1'b1;
    cmp_en = 1;

    repeat (6) put(8'h00);
    idle(1, 8'h00);
    chk("idle_busy", load_busy, 0);
    chk("idle_w", weights, 0);

    send(8'h00, 0, 159);
    pin_good();
    idle(2, 8'h00);

    send(8'h00, 1, 317);
    pin_good();
    idle(2, 8'h00);

    send(8'h01, 0, 159);
    chk("bad_err",  load_error, 1'b1);
    chk("bad_cv",   config_valid, 1'b0);
    chk("bad_busy", load_busy, 1'b0);
    idle(2, 8'h00);

    send(8'h00, 0, 159);
    pin_good();
    idle(2, 8'h00);

    build(8'h00);
    for (int i = 0; i < 1 + 52 + 40; i++) put(fr[i]);
    put(fr[93]);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_w",  weights, 0);
    chk("arst_d",  delays, 0);
    chk("arst_busy", load_busy, 0);
    chk("arst_thr", threshold, 0);
    #3 rst_n = 1'b1;
    bus.data_valid = 1'b0;
    idle(2, 8'h00);

    send(8'h00, 0, 159);
    pin_good();

    put(8'h5A);
    @(posedge clk);
    #1;
    chk("stray_cv", config_valid, 1'b1);
    chk("stray_busy", load_busy, 1'b0);
    put(8'hA5);
    @(posedge clk);
    #1;
    bus.data_valid = 1'b0;
    chk("rehdr_cv", config_valid, 1'b0);
    chk("rehdr_busy", load_busy, 1'b1);
    idle(3, 8'h00);

    cmp_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
